counter_loop_2d: RTL and testbench

- Parametrised two-level (outer × inner) loop counter with a start/done handshake.
- Successor to the single-level 7-bit wrap counter. Generalised widths; limits latched at start; one-shot or continuous mode; abort; final-index flag.
- Drives index generation for nested loops in the MFCC datapath, e.g. frame × filter-bank and frame × cepstral coefficient address sequencing.

---
 rtl/counter_loop_2d_pkg.sv | 13 +
 rtl/counter_loop_2d_stage.sv | 36 +++
 rtl/counter_loop_2d.sv | 117 +++++++++++
 tb/tb_counter_loop_2d.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_loop_2d_pkg.sv
// Shared definitions for the two-level loop counter: state encoding and default widths.
package counter_loop_2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int INNER_WIDTH_DEF = 7;
  localparam int OUTER_WIDTH_DEF = 6;

endpackage

// File: rtl/counter_loop_2d_stage.sv
// One loop level: counts up to an inclusive limit, then wraps to zero on the next enable.
module counter_loop_stage #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             at_limit
);

  logic [WIDTH-1:0] cnt_r;

  assign out      = cnt_r;
  assign at_limit = (cnt_r == limit);

  // Index register: clear dominates, wrap at the limit, otherwise increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (en) begin
      if (at_limit) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + WIDTH'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/counter_loop_2d.sv
// Two-level (outer x inner) loop index generator with start/done handshake,
// one-shot or continuous mode, and synchronous abort.
module counter_loop_2d
  import counter_loop_2d_pkg::*;
#(
  parameter int INNER_WIDTH = INNER_WIDTH_DEF,
  parameter int OUTER_WIDTH = OUTER_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cont_mode,
  input  logic                   adv,
  input  logic [INNER_WIDTH-1:0] inner_limit,
  input  logic [OUTER_WIDTH-1:0] outer_limit,
  output logic [INNER_WIDTH-1:0] inner_out,
  output logic [OUTER_WIDTH-1:0] outer_out,
  output logic                   valid,
  output logic                   inner_over,
  output logic                   outer_over,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_r;
  state_t                 state_s;
  logic [INNER_WIDTH-1:0] inner_lim_r;
  logic [OUTER_WIDTH-1:0] outer_lim_r;
  logic                   mode_r;
  logic                   load_s;
  logic                   clear_s;
  logic                   inner_at_s;
  logic                   outer_at_s;

  // Indices are held at zero outside RUN and on abort, so the stages need no state knowledge.
  assign clear_s = abort || (state_r != ST_RUN);

  counter_loop_stage #(.WIDTH(INNER_WIDTH)) u_inner (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .clear    (clear_s),
    .limit    (inner_lim_r),
    .out      (inner_out),
    .at_limit (inner_at_s)
  );

  counter_loop_stage #(.WIDTH(OUTER_WIDTH)) u_outer (
    .clk      (clk),
    .rst      (rst),
    .en       (adv && inner_at_s),
    .clear    (clear_s),
    .limit    (outer_lim_r),
    .out      (outer_out),
    .at_limit (outer_at_s)
  );

  // Next-state logic; abort has priority over start and adv.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (adv && inner_at_s && outer_at_s && !mode_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and configuration latched only when a sequence is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      inner_lim_r <= '0;
      outer_lim_r <= '0;
      mode_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        inner_lim_r <= inner_limit;
        outer_lim_r <= outer_limit;
        mode_r      <= cont_mode;
      end else begin
        inner_lim_r <= inner_lim_r;
        outer_lim_r <= outer_lim_r;
        mode_r      <= mode_r;
      end
    end
  end

  assign valid      = (state_r == ST_RUN);
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign inner_over = valid && inner_at_s;
  assign outer_over = inner_over && outer_at_s;

endmodule

// File: tb/tb_counter_loop_2d.sv
// Self-checking bench for counter_loop_2d: arithmetic index model plus directed scenarios.
module tb_counter_loop_2d;

  localparam int IW = 7;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cont_mode;
  logic          adv;
  logic [IW-1:0] inner_limit;
  logic [OW-1:0] outer_limit;
  logic [IW-1:0] inner_out;
  logic [OW-1:0] outer_out;
  logic          valid;
  logic          inner_over;
  logic          outer_over;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  counter_loop_2d #(.INNER_WIDTH(IW), .OUTER_WIDTH(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cont_mode   (cont_mode),
    .adv         (adv),
    .inner_limit (inner_limit),
    .outer_limit (outer_limit),
    .inner_out   (inner_out),
    .outer_out   (outer_out),
    .valid       (valid),
    .inner_over  (inner_over),
    .outer_over  (outer_over),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: a sequence is the linear iteration number k; indices are derived arithmetically.
  bit m_active;
  bit m_done;
  int m_k;
  int m_il;
  int m_ol;
  bit m_cont;
  int m_tot;
  assign m_tot = (m_il + 1) * (m_ol + 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_k <= 0; m_il <= 0; m_ol <= 0; m_cont <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_active) begin
      if (abort) begin
        m_active <= 1'b0; m_k <= 0;
      end else if (adv) begin
        if (m_k + 1 == m_tot) begin
          m_k <= 0;
          if (!m_cont) begin
            m_active <= 1'b0; m_done <= 1'b1;
          end
        end else begin
          m_k <= m_k + 1;
        end
      end
    end else if (start && !abort) begin
      m_active <= 1'b1; m_k <= 0;
      m_il <= int'(inner_limit); m_ol <= int'(outer_limit); m_cont <= cont_mode;
    end
  end

  int n_valid = 0;
  int n_done = 0;
  int n_iover = 0;
  int n_oover = 0;
  int n_advv = 0;
  int seq[$];

  function automatic int ix(input int o, input int i);
    return o * 256 + i;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    int ei, eo;
    bit eio, eoo;
    ei  = m_active ? (m_k % (m_il + 1)) : 0;
    eo  = m_active ? (m_k / (m_il + 1)) : 0;
    eio = m_active && (ei == m_il);
    eoo = eio && (eo == m_ol);
    chk("cycle{valid,busy,done,iover,oover,outer,inner}",
        {14'd0, valid, busy, done, inner_over, outer_over, outer_out, inner_out},
        {14'd0, m_active, (m_active || m_done), m_done, eio, eoo, OW'(eo), IW'(ei)});
  endtask

  task automatic tick();
    if (valid && adv) n_advv++;
    @(posedge clk);
    #1;
    compare_cycle();
    if (valid) begin
      n_valid++;
      seq.push_back(ix(int'(outer_out), int'(inner_out)));
    end
    if (done) n_done++;
    if (inner_over) n_iover++;
    if (outer_over) n_oover++;
  endtask

  task automatic start_seq(input int il, input int ol, input bit cm);
    inner_limit = IW'(il);
    outer_limit = OW'(ol);
    cont_mode   = cm;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while (busy && i < bound) begin
      tick();
      i++;
    end
    if (busy) chk("wait_idle_timeout_busy", {31'd0, busy}, 32'd0);
  endtask

  int bv, bd, bi, bo, ba, bs;
  task automatic snap();
    bv = n_valid; bd = n_done; bi = n_iover; bo = n_oover; ba = n_advv; bs = seq.size();
  endtask

  bit stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cont_mode = 1'b0; adv = 1'b1;
    inner_limit = '0; outer_limit = '0;
    repeat (3) tick();
    chk("reset_outputs", {14'd0, valid, busy, done, inner_over, outer_over, outer_out, inner_out}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("idle_rst_pulse", {14'd0, valid, busy, done, inner_over, outer_over, outer_out, inner_out}, 32'd0);

    // Basic one-shot 3/2
    snap();
    start_seq(3, 2, 1'b0);
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_idx", ix(int'(outer_out), int'(inner_out)), 32'd0);
    wait_idle(100);
    chk("oneshot_valid_cycles", n_valid - bv, 32'd12);
    chk("oneshot_done_pulses", n_done - bd, 32'd1);
    chk("oneshot_inner_over", n_iover - bi, 32'd3);
    chk("oneshot_outer_over", n_oover - bo, 32'd1);
    chk("oneshot_idx5", seq[bs + 5], ix(1, 1));
    chk("oneshot_last", seq[bs + 11], ix(2, 3));

    // Stall pattern 1,0,0,1
    snap();
    start_seq(3, 2, 1'b0);
    for (int c = 0; c < 200 && busy; c++) begin
      adv = stall_pat[c % 4];
      tick();
    end
    adv = 1'b1;
    chk("stall_adv_cycles", n_advv - ba, 32'd12);
    chk("stall_valid_cycles", n_valid - bv, 32'd24);
    chk("stall_done", n_done - bd, 32'd1);

    // Continuous 1/1
    snap();
    start_seq(1, 1, 1'b1);
    repeat (11) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("cont_valid_cycles", n_valid - bv, 32'd12);
    chk("cont_outer_over", n_oover - bo, 32'd3);
    chk("cont_idx6", seq[bs + 6], ix(1, 0));
    chk("cont_no_done", n_done - bd, 32'd0);
    chk("cont_abort_idle", {31'd0, busy}, 32'd0);

    // Degenerate 0/0
    snap();
    start_seq(0, 0, 1'b0);
    wait_idle(10);
    chk("zero_valid", n_valid - bv, 32'd1);
    chk("zero_outer_over", n_oover - bo, 32'd1);
    chk("zero_done", n_done - bd, 32'd1);

    // Full range 127/63
    snap();
    start_seq(127, 63, 1'b0);
    wait_idle(9000);
    chk("full_valid", n_valid - bv, 32'd8192);
    chk("full_inner_over", n_iover - bi, 32'd64);
    chk("full_done", n_done - bd, 32'd1);
    chk("full_last", seq[bs + 8191], ix(63, 127));

    // Abort at (2,1)
    snap();
    start_seq(3, 2, 1'b0);
    repeat (6) tick();
    chk("abort_pre_idx", ix(int'(outer_out), int'(inner_out)), ix(1, 2));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", {30'd0, busy, valid}, 32'd0);
    repeat (3) tick();
    chk("abort_no_done", n_done - bd, 32'd0);

    // Abort and start together in IDLE
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort_start_idle", {31'd0, busy}, 32'd0);

    // Start and limit changes during RUN ignored
    snap();
    start_seq(3, 2, 1'b0);
    repeat (3) tick();
    start = 1'b1; inner_limit = IW'(1); outer_limit = OW'(5); cont_mode = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(100);
    chk("ignore_valid", n_valid - bv, 32'd12);
    chk("ignore_last", seq[bs + 11], ix(2, 3));
    chk("ignore_done", n_done - bd, 32'd1);

    // Async reset mid-RUN at (1,1)
    start_seq(3, 2, 1'b0);
    repeat (5) tick();
    chk("arst_pre_idx", ix(int'(outer_out), int'(inner_out)), ix(1, 1));
    #2 rst = 1'b1;
    #1;
    compare_cycle();
    chk("arst_immediate", {14'd0, valid, busy, done, inner_over, outer_over, outer_out, inner_out}, 32'd0);
    tick();
    rst = 1'b0;
    snap();
    start_seq(1, 2, 1'b0);
    wait_idle(50);
    chk("arst_restart_valid", n_valid - bv, 32'd6);
    chk("arst_restart_done", n_done - bd, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
